// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Staggered multi-channel reset release with clock-gate enables.
//            Optional reverse-order shutdown walk when RESET_SEQ_SHUTDOWN_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shutdown_i,
    output logic [NUM_CH-1:0] gate_clk_en_o,
    output logic [NUM_CH-1:0] release_reset_o,
    output logic              done_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] C_CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_RUN      = 3'd2
`ifdef RESET_SEQ_SHUTDOWN_EN
        ,
        ST_SHUTDOWN = 3'd3,
        ST_HALT     = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] gate_q, gate_d;
    logic [NUM_CH-1:0] rel_q, rel_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  idx_up;
    logic [IDX_W-1:0]  idx_dn;

    assign cnt_inc = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + C_CNT_ONE;
    assign idx_up  = idx_q + C_IDX_ONE;
    assign idx_dn  = idx_q - C_IDX_ONE;

`ifndef RESET_SEQ_SHUTDOWN_EN
    logic unused_shutdown;
    assign unused_shutdown = shutdown_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        gate_d  = gate_q;
        rel_d   = rel_q;
        done_d  = done_q;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    gate_d[0] = 1'b1;
                    state_d   = ST_RELEASE;
                    cnt_d     = '0;
                    idx_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // cnt counts cycles since gate[idx] rose: release follows at 0,
            // next gate at STAGGER-1 (both on one edge when STAGGER==1).
            ST_RELEASE: begin
                cnt_d = cnt_inc;
                if (cnt_q == '0) begin
                    rel_d[idx_q] = 1'b1;
                end
                if (idx_q == C_IDX_LAST) begin
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == C_STAG_LAST) begin
                    gate_d[idx_up] = 1'b1;
                    idx_d          = idx_up;
                    cnt_d          = '0;
                end
            end

            ST_RUN: begin
            end

`ifdef RESET_SEQ_SHUTDOWN_EN
            // Mirror of RELEASE: gate drops one cycle after its release,
            // next-lower release drops at STAGGER-1.
            ST_SHUTDOWN: begin
                cnt_d = cnt_inc;
                if (cnt_q == '0) begin
                    gate_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_HALT;
                        cnt_d   = '0;
                    end
                end
                if ((idx_q != '0) && (cnt_q == C_STAG_LAST)) begin
                    rel_d[idx_dn] = 1'b0;
                    idx_d         = idx_dn;
                    cnt_d         = '0;
                end
            end

            ST_HALT: begin
                gate_d = '0;
                rel_d  = '0;
                done_d = 1'b0;
                if (!shutdown_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
`endif

            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                gate_d  = '0;
                rel_d   = '0;
                done_d  = 1'b0;
            end
        endcase

`ifdef RESET_SEQ_SHUTDOWN_EN
        // idx_q is the highest gated channel in both RELEASE and RUN.
        if (shutdown_i && ((state_q == ST_RELEASE) || (state_q == ST_RUN))) begin
            state_d      = ST_SHUTDOWN;
            gate_d       = gate_q;
            rel_d        = rel_q;
            rel_d[idx_q] = 1'b0;
            idx_d        = idx_q;
            cnt_d        = '0;
            done_d       = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            gate_q  <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            gate_q  <= gate_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    assign gate_clk_en_o   = gate_q;
    assign release_reset_o = rel_q;
    assign done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Self-checking bench for reset_sequencer (table, corner cases,
//            randomized run against a timing-formula reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int H = 8;
    localparam int S = 4;
`ifdef RESET_SEQ_SHUTDOWN_EN
    localparam bit SHUT_EN = 1'b1;
`else
    localparam bit SHUT_EN = 1'b0;
`endif

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         shutdown_i = 1'b0;
    logic [N-1:0] gate;
    logic [N-1:0] rel;
    logic         done;

    reset_sequencer #(
        .NUM_CH      (N),
        .HOLD_CYCLES (H),
        .STAGGER     (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .shutdown_i      (shutdown_i),
        .gate_clk_en_o   (gate),
        .release_reset_o (rel),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = sequencing (m_e low-reset edges so far),
    // 1 = shutdown walk (m_d edges since entry from top channel m_h), 2 = halted.
    int           m_mode = 0;
    int           m_e    = 0;
    int           m_d    = 0;
    int           m_h    = 0;
    logic [N-1:0] m_entry_rel = '0;
    logic [N-1:0] exp_gate;
    logic [N-1:0] exp_rel;
    logic         exp_done;

    task automatic model_edge(input logic r, input logic sd);
        if (r) begin
            m_mode = 0;
            m_e    = 0;
        end else if (m_mode == 0) begin
            if (SHUT_EN && sd && (m_e >= H)) begin
                m_h = 0;
                for (int i = 0; i < N; i++) if (m_e >= H + i * S) m_h = i;
                for (int k = 0; k < N; k++) m_entry_rel[k] = (m_e >= H + k * S + 1);
                m_mode = 1;
                m_d    = 0;
            end else begin
                m_e++;
            end
        end else if (m_mode == 1) begin
            m_d++;
            if (m_d == m_h * S + 1) m_mode = 2;
        end else if (!sd) begin
            m_mode = 0;
            m_e    = 0;
        end

        exp_gate = '0;
        exp_rel  = '0;
        exp_done = 1'b0;
        if (m_mode == 0) begin
            for (int k = 0; k < N; k++) begin
                exp_gate[k] = (m_e >= H + k * S);
                exp_rel[k]  = (m_e >= H + k * S + 1);
            end
            exp_done = (m_e >= H + (N - 1) * S + 2);
        end else if (m_mode == 1) begin
            for (int k = 0; k <= m_h; k++) begin
                exp_gate[k] = (m_d < (m_h - k) * S + 1);
                exp_rel[k]  = m_entry_rel[k] && (m_d < (m_h - k) * S);
            end
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] g,
                         input logic [N-1:0] r, input logic dn);
        n_tests++;
        if ((gate !== g) || (rel !== r) || (done !== dn)) begin
            n_fail++;
            $display("FAIL %s: got gate=%b rel=%b done=%b, want gate=%b rel=%b done=%b",
                     name, gate, rel, done, g, r, dn);
        end
    endtask

    task automatic step(input logic r, input logic sd, input string name);
        reset      = r;
        shutdown_i = sd;
        @(posedge clk);
        #1;
        model_edge(r, sd);
        check({name, "/model"}, exp_gate, exp_rel, exp_done);
        n_tests++;
        if ((rel & ~gate) != '0) begin
            n_fail++;
            $display("FAIL %s/invariant: got gate=%b rel=%b, want no rel bit without gate",
                     name, gate, rel);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         sd;
        int           ncyc;
        logic [N-1:0] g;
        logic [N-1:0] r;
        logic         dn;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Power-up sequence, expectations hand-derived from the timing table.
        tbl.push_back('{1'b1, 1'b0, 3, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 7, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0001, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0001, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3, 4'b0011, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0011, 4'b0011, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 7, 4'b1111, 4'b0111, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b1111, 4'b1111, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b1111, 4'b1111, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5, 4'b1111, 4'b1111, 1'b1});
`ifdef RESET_SEQ_SHUTDOWN_EN
        tbl.push_back('{1'b0, 1'b1, 1, 4'b1111, 4'b0111, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0111, 4'b0111, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3, 4'b0111, 4'b0011, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0011, 4'b0011, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 7, 4'b0001, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8, 4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1, 4'b0001, 4'b0000, 1'b0});
`else
        tbl.push_back('{1'b0, 1'b1, 6, 4'b1111, 4'b1111, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 6, 4'b1111, 4'b1111, 1'b1});
`endif

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].ncyc; c++) step(tbl[i].rst, tbl[i].sd, "table");
            check($sformatf("vec[%0d]", i), tbl[i].g, tbl[i].r, tbl[i].dn);
        end

        // Reset pulse mid-RELEASE restarts the whole sequence.
        step(1'b1, 1'b0, "rst_mid");
        step(1'b1, 1'b0, "rst_mid");
        for (int c = 0; c < 14; c++) step(1'b0, 1'b0, "rst_mid");
        check("rst_mid_pre", 4'b0011, 4'b0011, 1'b0);
        step(1'b1, 1'b0, "rst_mid");
        check("rst_mid_clear", 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b0, "rst_mid");
        check("rst_mid_hold", 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b0, "rst_mid");
        check("rst_mid_gate0", 4'b0001, 4'b0000, 1'b0);

        // Shutdown request while channel 1 is the highest gated channel.
        step(1'b1, 1'b0, "sd_mid");
        for (int c = 0; c < 14; c++) step(1'b0, 1'b0, "sd_mid");
        step(1'b0, 1'b1, "sd_mid");
`ifdef RESET_SEQ_SHUTDOWN_EN
        check("sd_mid_entry", 4'b0011, 4'b0001, 1'b0);
        step(1'b0, 1'b0, "sd_mid");
        check("sd_mid_gate1_off", 4'b0001, 4'b0001, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, "sd_mid");
        check("sd_mid_rel0_off", 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 1'b0, "sd_mid");
        check("sd_mid_gate0_off", 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, "sd_mid");
        check("sd_mid_rehold", 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b0, "sd_mid");
        check("sd_mid_regate0", 4'b0001, 4'b0000, 1'b0);
`else
        check("sd_mid_ignored", 4'b0011, 4'b0011, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, "sd_mid");
        check("sd_mid_run", 4'b1111, 4'b1111, 1'b1);
`endif

        // Randomized reset/shutdown traffic against the model.
        begin
            logic sd_lvl;
            sd_lvl = 1'b0;
            for (int c = 0; c < 10000; c++) begin
                if ($urandom_range(0, 29) == 0) sd_lvl = ~sd_lvl;
                step(($urandom_range(0, 299) == 0), sd_lvl, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
